// File: rtl/dmem_pkg.sv
// dmem_ctrl shared definitions: funct3 codes, FSM states and the
// alignment/legality check used by the lane unit.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WSETUP,
        S_WSTROBE,
        S_RESP
    } state_e;

    function automatic logic lane_err(
        input logic       we,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic e;
        e = 1'b0;
        if (we) begin
            case (f3)
                F3_B:    e = 1'b0;
                F3_H:    e = off[0];
                F3_W:    e = (off != 2'b00);
                default: e = 1'b1;
            endcase
        end else begin
            case (f3)
                F3_B, F3_BU: e = 1'b0;
                F3_H, F3_HU: e = off[0];
                F3_W:        e = (off != 2'b00);
                default:     e = 1'b1;
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte/halfword lane unit: load extract and extend, store merge into
// the read word, and the misalignment/illegal-funct3 check.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o,
    output logic        err_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rword_i[7:0];
        case (off_i)
            2'd0:    byte_v = rword_i[7:0];
            2'd1:    byte_v = rword_i[15:8];
            2'd2:    byte_v = rword_i[23:16];
            default: byte_v = rword_i[31:24];
        endcase
        half_v = off_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    always_comb begin
        load_o = '0;
        case (funct3_i)
            F3_B:    load_o = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_o = {24'd0, byte_v};
            F3_H:    load_o = {{16{half_v[15]}}, half_v};
            F3_HU:   load_o = {16'd0, half_v};
            F3_W:    load_o = rword_i;
            default: load_o = '0;
        endcase
    end

    always_comb begin
        merge_o = rword_i;
        case (funct3_i)
            F3_B: begin
                case (off_i)
                    2'd0:    merge_o[7:0]   = wdata_i[7:0];
                    2'd1:    merge_o[15:8]  = wdata_i[7:0];
                    2'd2:    merge_o[23:16] = wdata_i[7:0];
                    default: merge_o[31:24] = wdata_i[7:0];
                endcase
            end
            F3_H: begin
                if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
                else          merge_o[15:0]  = wdata_i[15:0];
            end
            F3_W:    merge_o = wdata_i;
            default: merge_o = rword_i;
        endcase
    end

    assign err_o = lane_err(we_i, funct3_i, off_i);

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port round-robin data-memory controller with registered strobes
// and read-modify-write for sub-word stores.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [31:0]       wdata0,
    input  logic [2:0]        funct30,
    input  logic [31:0]       pc0,
    output logic              gnt0,
    output logic              done0,
    output logic              err0,
    output logic [31:0]       rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    input  logic [2:0]        funct31,
    input  logic [31:0]       pc1,
    output logic              gnt1,
    output logic              done1,
    output logic              err1,
    output logic [31:0]       rdata1,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memReadEnable,
    input  logic [31:0]       memReadData,
    output logic              memWriteEnable,
    output logic [31:0]       memWriteData,
    output logic [31:0]       PC
);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic              mre_q, mre_d;
    logic              mwe_q, mwe_d;
    logic [31:0]       mwd_q, mwd_d;
    logic [31:0]       pc_q, pc_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;

    logic              any_req, sel, idle;
    logic              s_we;
    logic [2:0]        s_f3;
    logic [ADDR_W-1:0] s_addr;
    logic [31:0]       s_wdata, s_pc;

    logic              l_we, l_err;
    logic [2:0]        l_f3;
    logic [1:0]        l_off;
    logic [31:0]       l_wdata, l_load, l_merge;

    // On a tie the port not granted last time wins.
    assign any_req = req0 | req1;
    assign sel     = (req0 & req1) ? ~last_q : req1;
    assign idle    = (state_q == S_IDLE);

    assign s_we    = sel ? we1     : we0;
    assign s_f3    = sel ? funct31 : funct30;
    assign s_addr  = sel ? addr1   : addr0;
    assign s_wdata = sel ? wdata1  : wdata0;
    assign s_pc    = sel ? pc1     : pc0;

    // One lane unit: fed by the incoming request in IDLE, by latches after.
    assign l_we    = idle ? s_we         : we_q;
    assign l_f3    = idle ? s_f3         : f3_q;
    assign l_off   = idle ? s_addr[1:0]  : off_q;
    assign l_wdata = idle ? s_wdata      : wdata_q;

    dmem_lane u_lane (
        .we_i     (l_we),
        .funct3_i (l_f3),
        .off_i    (l_off),
        .rword_i  (memReadData),
        .wdata_i  (l_wdata),
        .load_o   (l_load),
        .merge_o  (l_merge),
        .err_o    (l_err)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        maddr_d = maddr_q;
        mwd_d   = mwd_q;
        pc_d    = pc_q;
        mre_d   = 1'b0;
        mwe_d   = 1'b0;
        gnt_d   = '0;
        done_d  = '0;
        err_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d[sel] = 1'b1;
                    last_d     = sel;
                    owner_d    = sel;
                    we_d       = s_we;
                    f3_d       = s_f3;
                    off_d      = s_addr[1:0];
                    wdata_d    = s_wdata;
                    pc_d       = s_pc;
                    maddr_d    = {s_addr[ADDR_W-1:2], 2'b00};
                    if (l_err) begin
                        state_d    = S_RESP;
                        done_d[sel] = 1'b1;
                        err_d[sel]  = 1'b1;
                        rdata_d    = '0;
                    end else if (s_we && s_f3 == F3_W) begin
                        state_d = S_WSETUP;
                        mwd_d   = l_merge;
                    end else begin
                        state_d = S_RD;
                        mre_d   = 1'b1;
                    end
                end
            end
            S_RD: begin
                if (we_q) begin
                    state_d = S_WSETUP;
                    mwd_d   = l_merge;
                end else begin
                    state_d         = S_RESP;
                    rdata_d         = l_load;
                    done_d[owner_q] = 1'b1;
                end
            end
            S_WSETUP: begin
                state_d = S_WSTROBE;
                mwe_d   = 1'b1;
            end
            S_WSTROBE: begin
                state_d         = S_RESP;
                rdata_d         = '0;
                done_d[owner_q] = 1'b1;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            maddr_q <= '0;
            mre_q   <= 1'b0;
            mwe_q   <= 1'b0;
            mwd_q   <= '0;
            pc_q    <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            maddr_q <= maddr_d;
            mre_q   <= mre_d;
            mwe_q   <= mwe_d;
            mwd_q   <= mwd_d;
            pc_q    <= pc_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign gnt0           = gnt_q[0];
    assign gnt1           = gnt_q[1];
    assign done0          = done_q[0];
    assign done1          = done_q[1];
    assign err0           = err_q[0];
    assign err1           = err_q[1];
    assign rdata0         = rdata_q;
    assign rdata1         = rdata_q;
    assign memAddr        = maddr_q;
    assign memReadEnable  = mre_q;
    assign memWriteEnable = mwe_q;
    assign memWriteData   = mwd_q;
    assign PC             = pc_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: behavioural RAM, write-strobe monitor
// and per-transaction response/latency checks.
module tb_dmem_ctrl;

    typedef struct {
        bit          port;
        bit          err;
        bit          chk_rd;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [31:0] addr0 = 0, wdata0 = 0, pc0 = 0;
    logic [31:0] addr1 = 0, wdata1 = 0, pc1 = 0;
    logic [2:0]  funct30 = 0, funct31 = 0;
    logic        gnt0, done0, err0, gnt1, done1, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] memAddr, memReadData, memWriteData, PC;
    logic        memReadEnable, memWriteEnable;

    logic [31:0] ram [0:63] = '{default: '0};

    exp_t sb[$];
    wr_t  wq[$];
    bit   glog[$];
    int   n_chk = 0, n_err = 0;
    int   cyc = 0, nrd = 0, nwr = 0, n_done = 0;
    int   gcyc [2];
    logic        prev_we = 1'b0;
    logic [31:0] prev_addr = '0, prev_data = '0;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .req0           (req0),
        .we0            (we0),
        .addr0          (addr0),
        .wdata0         (wdata0),
        .funct30        (funct30),
        .pc0            (pc0),
        .gnt0           (gnt0),
        .done0          (done0),
        .err0           (err0),
        .rdata0         (rdata0),
        .req1           (req1),
        .we1            (we1),
        .addr1          (addr1),
        .wdata1         (wdata1),
        .funct31        (funct31),
        .pc1            (pc1),
        .gnt1           (gnt1),
        .done1          (done1),
        .err1           (err1),
        .rdata1         (rdata1),
        .memAddr        (memAddr),
        .memReadEnable  (memReadEnable),
        .memReadData    (memReadData),
        .memWriteEnable (memWriteEnable),
        .memWriteData   (memWriteData),
        .PC             (PC)
    );

    assign memReadData = ram[memAddr[7:2]];

    always @(posedge memWriteEnable) ram[memAddr[7:2]] <= memWriteData;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Grants, responses and write strobes, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        bit   p;
        if (gnt0) begin gcyc[0] = cyc; glog.push_back(1'b0); end
        if (gnt1) begin gcyc[1] = cyc; glog.push_back(1'b1); end
        if (memReadEnable) nrd++;
        if (done0 || done1) begin
            n_done++;
            p = done1;
            chk("sb_pending", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("done_port", {31'd0, p}, {31'd0, e.port});
                chk("err", {31'd0, p ? err1 : err0}, {31'd0, e.err});
                if (e.chk_rd) chk("rdata", p ? rdata1 : rdata0, e.rdata);
                chk("latency", cyc - gcyc[p] + 1, e.lat);
            end
        end
        if (memWriteEnable) begin
            nwr++;
            chk("we_width", {31'd0, prev_we}, 32'd0);
            chk("wr_setup_addr", memAddr, prev_addr);
            chk("wr_setup_data", memWriteData, prev_data);
            chk("wr_expected", (wq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (wq.size() > 0) begin
                w = wq.pop_front();
                chk("wr_addr", memAddr, w.addr);
                chk("wr_data", memWriteData, w.data);
                chk("wr_pc", PC, w.pc);
            end
        end else if (prev_we) begin
            chk("wr_hold_addr", memAddr, prev_addr);
            chk("wr_hold_data", memWriteData, prev_data);
        end
        prev_we   = memWriteEnable;
        prev_addr = memAddr;
        prev_data = memWriteData;
    end

    task automatic drive(input bit p, input logic r, input logic we,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] pc);
        if (p) begin
            req1 = r; we1 = we; funct31 = f3; addr1 = a; wdata1 = wd; pc1 = pc;
        end else begin
            req0 = r; we0 = we; funct30 = f3; addr0 = a; wdata0 = wd; pc0 = pc;
        end
    endtask

    task automatic push_exp(input bit p, input bit we, input bit e_err,
                            input logic [31:0] e_rd, input int lat);
        exp_t e;
        e.port   = p;
        e.err    = e_err;
        e.chk_rd = !we || e_err;
        e.rdata  = e_rd;
        e.lat    = lat;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        chk("done_timeout", sb.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic issue(input bit p, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] pc, input bit e_err,
                         input logic [31:0] e_val, input int lat);
        bit got;
        wr_t w;
        push_exp(p, we, e_err, e_err ? 32'd0 : e_val, lat);
        if (we && !e_err) begin
            w.addr = {a[31:2], 2'b00};
            w.data = e_val;
            w.pc   = pc;
            wq.push_back(w);
        end
        drive(p, 1'b1, we, f3, a, wd, pc);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = p ? gnt1 : gnt0;
        end
        chk("gnt_timeout", {31'd0, got}, 32'd1);
        drive(p, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
        wait_done();
    endtask

    task automatic arb_port(input bit p, input logic [31:0] a);
        int cnt;
        cnt = 0;
        drive(p, 1'b1, 1'b0, 3'd2, a, 32'd0, 32'd0);
        for (int i = 0; i < 200 && cnt < 3; i++) begin
            @(negedge clk);
            if (p ? gnt1 : gnt0) cnt++;
        end
        drive(p, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
        chk("arb_grants", cnt, 32'd3);
    endtask

    initial begin
        int d0, w0, r0;
        bit got;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_done0", {31'd0, done0}, 32'd0);
        chk("rst_err1", {31'd0, err1}, 32'd0);
        chk("rst_we", {31'd0, memWriteEnable}, 32'd0);
        chk("rst_re", {31'd0, memReadEnable}, 32'd0);
        chk("rst_addr", memAddr, 32'd0);
        chk("rst_wdata", memWriteData, 32'd0);
        chk("rst_pc", PC, 32'd0);
        chk("rst_rdata", rdata0, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h100, 0, 32'hDEADBEEF, 3);
        chk("ram_sw", ram[4], 32'hDEADBEEF);

        issue(1, 1, 3'd2, 32'h20, 32'h11223344, 32'h0, 0, 32'h11223344, 3);
        issue(0, 1, 3'd0, 32'h22, 32'hFFFFFFAA, 32'h104, 0, 32'h11AA3344, 4);
        chk("ram_sb", ram[8], 32'h11AA3344);
        issue(0, 0, 3'd0, 32'h22, 32'h0, 32'h108, 0, 32'hFFFFFFAA, 2);
        issue(0, 0, 3'd4, 32'h22, 32'h0, 32'h10C, 0, 32'h000000AA, 2);
        issue(1, 0, 3'd5, 32'h22, 32'h0, 32'h0, 0, 32'h000011AA, 2);
        issue(1, 0, 3'd1, 32'h20, 32'h0, 32'h0, 0, 32'h00003344, 2);
        issue(0, 0, 3'd2, 32'h20, 32'h0, 32'h110, 0, 32'h11AA3344, 2);

        r0 = nrd; w0 = nwr;
        issue(0, 0, 3'd1, 32'h21, 32'h0, 32'h114, 1, 32'h0, 1);
        issue(0, 1, 3'd2, 32'h12, 32'h12345678, 32'h118, 1, 32'h0, 1);
        issue(1, 0, 3'd3, 32'h20, 32'h0, 32'h0, 1, 32'h0, 1);
        issue(0, 1, 3'd3, 32'h20, 32'h0, 32'h11C, 1, 32'h0, 1);
        issue(0, 1, 3'd1, 32'h23, 32'hBEEF, 32'h11E, 1, 32'h0, 1);
        chk("err_no_read", nrd, r0);
        chk("err_no_write", nwr, w0);
        chk("ram_after_err", ram[4], 32'hDEADBEEF);

        issue(0, 1, 3'd1, 32'h32, 32'h0000BEEF, 32'h200, 0, 32'hBEEF0000, 4);
        issue(0, 0, 3'd1, 32'h32, 32'h0, 32'h204, 0, 32'hFFFFBEEF, 2);

        // Store aborted by reset while the controller sits in WSETUP.
        d0 = n_done; w0 = nwr;
        drive(0, 1'b1, 1'b1, 3'd2, 32'h30, 32'h5A5A5A5A, 32'h300);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = gnt0;
        end
        chk("rst_gnt", {31'd0, got}, 32'd1);
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_mid_we", {31'd0, memWriteEnable}, 32'd0);
        chk("rst_mid_addr", memAddr, 32'd0);
        chk("rst_mid_pc", PC, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_no_done", n_done, d0);
        chk("rst_no_write", nwr, w0);
        chk("rst_ram", ram[12], 32'hBEEF0000);
        issue(0, 0, 3'd2, 32'h30, 32'h0, 32'h304, 0, 32'hBEEF0000, 2);

        // Both ports request continuously after a fresh reset.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        glog.delete();
        for (int i = 0; i < 6; i++)
            push_exp(i[0], 0, 0, i[0] ? 32'h11AA3344 : 32'hDEADBEEF, 2);
        fork
            arb_port(0, 32'h10);
            arb_port(1, 32'h20);
        join
        wait_done();
        chk("arb_count", glog.size(), 32'd6);
        for (int i = 0; i < 6 && i < glog.size(); i++)
            chk($sformatf("arb_order%0d", i), {31'd0, glog[i]}, {31'd0, i[0]});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
